// File: rtl/tagger_edge_generator_if.sv
// Event handshake bundle for the tagger edge generator: one timestamped
// pulse request (coarse time, sub-cycle sample index, width in samples).
interface tagger_edge_generator_if #(
    parameter int BITS    = 2,
    parameter int TIME_W  = 32,
    parameter int WIDTH_W = 8
);
    logic                 event_valid;
    logic                 event_ready;
    logic [TIME_W-1:0]    event_time;
    logic [BITS-1:0]      event_subtime;
    logic [WIDTH_W-1:0]   event_width;

    modport master (
        output event_valid,
        output event_time,
        output event_subtime,
        output event_width,
        input  event_ready
    );

    modport slave (
        input  event_valid,
        input  event_time,
        input  event_subtime,
        input  event_width,
        output event_ready
    );
endinterface

// File: rtl/tagger_edge_generator.sv
// Tagger edge generator: turns one timestamped event (coarse cycle, sample
// index within the cycle, width in samples) into a registered per-clock
// sample vector whose rising edge lands exactly at that sample position.
// Used as a calibration / loopback pulse source for the tagger inputs.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | ready for an event; late events are dropped here with a late pulse
// ARMED | event latched, waiting for cycle time-1 to load the first vector
// HIGH  | pulse spans further vectors; r_rem samples still to emit
module tagger_edge_generator #(
    parameter int BITS    = 2,
    parameter int TIME_W  = 32,
    parameter int WIDTH_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    tagger_edge_generator_if.slave   ev,
    output logic [(1<<BITS)-1:0]     samples,
    output logic [TIME_W-1:0]        now,
    output logic                     late
);

    localparam int N = 1 << BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HIGH  = 2'd2
    } state_t;

    state_t               r_state;
    logic [TIME_W-1:0]    r_now;
    logic [TIME_W-1:0]    r_time;
    logic [BITS-1:0]      r_subtime;
    logic [WIDTH_W-1:0]   r_width;
    logic [WIDTH_W:0]     r_rem;
    logic [N-1:0]         r_samples;
    logic                 r_late;

    logic [TIME_W-1:0]    w_diff;
    logic                 w_is_late;
    logic                 w_accept;
    logic                 w_fire;
    logic [WIDTH_W:0]     w_span;
    logic                 w_fits;
    logic [WIDTH_W:0]     w_rem_first;
    logic                 w_rem_gt_n;
    logic [N-1:0]         w_first_vec;
    logic [N-1:0]         w_tail_vec;

    // Wrap-aware lead: anything less than two cycles ahead, or in the
    // "past" half of the counter range, cannot be scheduled in time.
    assign w_diff      = ev.event_time - r_now;
    assign w_is_late   = (w_diff < TIME_W'(2)) || w_diff[TIME_W-1];
    assign w_accept    = (r_state == S_IDLE) && ev.event_valid;

    // The first vector is loaded one cycle early so it is visible in the
    // event cycle itself.
    assign w_fire      = (r_now == (r_time - TIME_W'(1)));

    // Samples available in the first vector from subtime to the end.
    assign w_span      = (WIDTH_W+1)'(N) - (WIDTH_W+1)'(r_subtime);
    assign w_fits      = ({1'b0, r_width} <= w_span);
    assign w_rem_first = {1'b0, r_width} - w_span;
    assign w_rem_gt_n  = (r_rem > (WIDTH_W+1)'(N));

    // Build the first (subtime-aligned) and final (tail) vectors; one mask
    // rule covers width 0, a pulse inside one vector and a spilling pulse.
    always_comb begin
        w_first_vec = '0;
        w_tail_vec  = '0;
        for (int i = 0; i < N; i++) begin
            if ((i >= int'(r_subtime)) && ((i - int'(r_subtime)) < int'(r_width)))
                w_first_vec[i] = 1'b1;
            if (i < int'(r_rem))
                w_tail_vec[i] = 1'b1;
        end
    end

    // Free-running coarse time counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_now <= '0;
        end else begin
            r_now <= r_now + TIME_W'(1);
        end
    end

    // Event FSM with registered sample vector and late pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_time    <= '0;
            r_subtime <= '0;
            r_width   <= '0;
            r_rem     <= '0;
            r_samples <= '0;
            r_late    <= 1'b0;
        end else begin
            r_late <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_samples <= '0;
                    if (w_accept) begin
                        if (w_is_late) begin
                            r_late <= 1'b1;
                        end else begin
                            r_time    <= ev.event_time;
                            r_subtime <= ev.event_subtime;
                            r_width   <= ev.event_width;
                            r_state   <= S_ARMED;
                        end
                    end
                end
                S_ARMED: begin
                    r_samples <= '0;
                    if (w_fire) begin
                        r_samples <= w_first_vec;
                        if (w_fits) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_rem   <= w_rem_first;
                            r_state <= S_HIGH;
                        end
                    end
                end
                S_HIGH: begin
                    if (w_rem_gt_n) begin
                        r_samples <= '1;
                        r_rem     <= r_rem - (WIDTH_W+1)'(N);
                    end else begin
                        r_samples <= w_tail_vec;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_samples <= '0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign ev.event_ready = (r_state == S_IDLE);
    assign samples        = r_samples;
    assign now            = r_now;
    assign late           = r_late;

endmodule

// File: tb/tb_tagger_edge_generator.sv
// Bench for tagger_edge_generator: directed table of events plus a reset
// during a long pulse, then randomized events checked against a model that
// marks absolute sample positions per unwrapped cycle.
module tb_tagger_edge_generator;

    localparam int BITS    = 2;
    localparam int TIME_W  = 8;
    localparam int WIDTH_W = 8;
    localparam int N       = 1 << BITS;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tagger_edge_generator_if #(.BITS(BITS), .TIME_W(TIME_W), .WIDTH_W(WIDTH_W)) ev_if ();

    logic [N-1:0]      samples;
    logic [TIME_W-1:0] now;
    logic              late;

    tagger_edge_generator #(.BITS(BITS), .TIME_W(TIME_W), .WIDTH_W(WIDTH_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .ev      (ev_if),
        .samples (samples),
        .now     (now),
        .late    (late)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;        // unwrapped cycle index since last reset release
    int free_at = 0;    // first cycle in which the model is ready again

    bit [N-1:0] exp_s [int];
    bit         exp_l [int];

    typedef struct {
        int         cyc;
        bit         is_late;
        logic [N-1:0] val;
    } dir_t;
    dir_t dir_q [$];

    typedef struct {
        int                 offer;
        int                 t;
        int                 s;
        int                 w;
        bit                 is_late;
        logic [0:3][N-1:0]  e;      // vectors at abs-1, abs, abs+1, abs+2
    } vec_t;

    function automatic void chk(string name, longint act, longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endfunction

    function automatic void model_accept(int t, int s, int w);
        int diff;
        int abs_t;
        diff = (t - cyc) & ((1 << TIME_W) - 1);
        if (diff < 2 || diff >= (1 << (TIME_W-1))) begin
            exp_l[cyc+1] = 1'b1;
        end else begin
            abs_t = cyc + diff;
            for (int k = 0; k < w; k++) begin
                int p;
                int c;
                p = s + k;
                c = abs_t + p / N;
                if (!exp_s.exists(c)) exp_s[c] = '0;
                exp_s[c] = exp_s[c] | (N'(1) << (p % N));
            end
            free_at = abs_t + ((w == 0) ? 0 : (s + w - 1) / N);
        end
    endfunction

    task automatic check_cycle();
        bit [N-1:0] es;
        es = exp_s.exists(cyc) ? exp_s[cyc] : '0;
        chk("samples", samples, es);
        chk("late", late, exp_l.exists(cyc) ? 1 : 0);
        chk("ready", ev_if.event_ready, (cyc >= free_at) ? 1 : 0);
        chk("now", now, cyc % (1 << TIME_W));
        for (int i = dir_q.size() - 1; i >= 0; i--) begin
            if (dir_q[i].cyc == cyc) begin
                if (dir_q[i].is_late) chk("dir_late", late, dir_q[i].val);
                else                  chk("dir_samples", samples, dir_q[i].val);
                dir_q.delete(i);
            end
        end
    endtask

    // Check the current cycle, drive inputs for it, advance one clock.
    task automatic run_cycle(input bit v, input int t, input int s, input int w, output bit acc);
        check_cycle();
        ev_if.event_valid   = v;
        ev_if.event_time    = TIME_W'(t);
        ev_if.event_subtime = BITS'(s);
        ev_if.event_width   = WIDTH_W'(w);
        acc = v && (cyc >= free_at);
        if (acc) model_accept(t, s, w);
        @(posedge clk);
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_to(input int c);
        bit acc;
        int n;
        n = 0;
        while (cyc < c && n < 2000) begin
            run_cycle(1'b0, 0, 0, 0, acc);
            n++;
        end
    endtask

    task automatic offer(input int t, input int s, input int w);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 300) begin
            run_cycle(1'b1, t, s, w, acc);
            n++;
        end
        if (!acc) chk("offer_timeout", 0, 1);
    endtask

    task automatic restart_model();
        cyc = 0;
        free_at = 0;
        exp_s.delete();
        exp_l.delete();
        dir_q.delete();
    endtask

    vec_t tbl [7];

    initial begin
        bit acc;
        bit hold;
        int rt, rs, rw, abs_t, hi_start;

        tbl[0] = '{5,   10, 1, 2, 1'b0, {4'b0000, 4'b0110, 4'b0000, 4'b0000}};
        tbl[1] = '{12,  20, 3, 6, 1'b0, {4'b0000, 4'b1000, 4'b1111, 4'b0001}};
        tbl[2] = '{30,  31, 0, 3, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0000}};
        tbl[3] = '{40,  39, 0, 3, 1'b1, {4'b0000, 4'b0000, 4'b0000, 4'b0000}};
        tbl[4] = '{45,  50, 2, 0, 1'b0, {4'b0000, 4'b0000, 4'b0000, 4'b0000}};
        tbl[5] = '{55,  60, 2, 6, 1'b0, {4'b0000, 4'b1100, 4'b1111, 4'b0000}};
        tbl[6] = '{61,  63, 0, 1, 1'b0, {4'b0000, 4'b0001, 4'b0000, 4'b0000}};

        ev_if.event_valid   = 1'b0;
        ev_if.event_time    = '0;
        ev_if.event_subtime = '0;
        ev_if.event_width   = '0;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_samples", samples, 0);
        chk("rst_now", now, 0);
        chk("rst_late", late, 0);
        chk("rst_ready", ev_if.event_ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        restart_model();

        // Directed table: each record schedules its expectations and is
        // offered at its own cycle; pulses may overlap the next record.
        for (int r = 0; r < 7; r++) begin
            abs_t = tbl[r].offer + ((tbl[r].t - tbl[r].offer) & 255);
            if (tbl[r].is_late) begin
                dir_q.push_back('{tbl[r].offer + 1, 1'b1, 4'b0001});
                dir_q.push_back('{tbl[r].offer + 2, 1'b1, 4'b0000});
            end else begin
                for (int k = 0; k < 4; k++)
                    dir_q.push_back('{abs_t - 1 + k, 1'b0, tbl[r].e[k]});
            end
            idle_to(tbl[r].offer);
            offer(tbl[r].t, tbl[r].s, tbl[r].w);
        end

        // Wrap: offered at now=254 for time 2.
        for (int k = 0; k < 4; k++)
            dir_q.push_back('{257 + k, 1'b0, (k == 1) ? 4'b1111 : 4'b0000});
        idle_to(254);
        offer(2, 0, 4);
        idle_to(265);
        chk("dir_left", dir_q.size(), 0);

        // Reset asserted while a 200-sample pulse is in HIGH.
        hi_start = cyc + 3;
        offer(hi_start & 255, 0, 200);
        idle_to(hi_start + 5);
        chk("high_before_rst", samples, 4'b1111);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_samples", samples, 0);
        chk("async_rst_now", now, 0);
        chk("async_rst_late", late, 0);
        chk("async_rst_ready", ev_if.event_ready, 1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        restart_model();
        idle_to(70);

        // Randomized events; a payload is held until accepted.
        hold = 1'b0;
        rt = 0; rs = 0; rw = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!hold && ($urandom % 3 == 0)) begin
                int sel, diff;
                sel = $urandom % 10;
                if (sel == 0)      diff = $urandom % 2;
                else if (sel == 1) diff = 128 + $urandom % 128;
                else if (sel == 2) diff = 127;
                else               diff = 2 + $urandom % 20;
                rt = (cyc + diff) & 255;
                rs = $urandom % N;
                sel = $urandom % 8;
                if (sel == 0)      rw = 0;
                else if (sel == 1) rw = 200 + $urandom % 56;
                else               rw = $urandom % 24;
                hold = 1'b1;
            end
            run_cycle(hold, rt, rs, rw, acc);
            if (acc) hold = 1'b0;
        end
        idle_to(cyc + 80);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tagger_edge_generator.md
# tagger_edge_generator

Inverse of the sample-to-subtime conversion in the tagger input path. It accepts one timestamped event at a time: a coarse clock-cycle time, a sub-cycle sample index and a pulse width in samples. It then drives a registered per-clock sample vector that a downstream serializer emits, which produces a rising edge at exactly that sample position. It is used as a calibration and loopback pulse source for the tagger inputs.

## Interface
- BITS, 2, log2 of samples per clock; N = 1<<BITS samples per vector
- TIME_W, 32, width of coarse time counter and event_time
- WIDTH_W, 8, width of event_width (pulse length in samples)
- clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- event_valid  in  1  event offered
- event_ready  out  1  event accepted on a cycle where valid && ready
- event_time  in  TIME_W  coarse cycle in which the rising edge appears on samples
- event_subtime  in  BITS  index of the first high sample in that cycle (sample 0 is earliest)
- event_width  in  WIDTH_W  number of consecutive high samples; 0 = no pulse
- samples  out  N  registered sample vector, bit i = sample i of this cycle
- now  out  TIME_W  free-running coarse counter
- late  out  1  one-cycle pulse: last accepted event was dropped as late

## Operation
- now: reset to 0, increments by 1 every cycle, wraps modulo 2^TIME_W.
- States: IDLE, ARMED, HIGH. event_ready = (state == IDLE).
- Acceptance in IDLE: diff = (event_time - now) mod 2^TIME_W.
  - diff in {0, 1} or diff >= 2^(TIME_W-1): event is late. It is dropped, late = 1 next cycle, and the block stays IDLE.
  - Otherwise latch time, subtime and width, and go to ARMED.
- ARMED: samples = 0. In the cycle where now == latched_time - 1, load the first vector:
  - width == 0: samples stays 0; go to IDLE.
  - width <= N - subtime: bits [subtime .. subtime+width-1] high, others low; go to IDLE.
  - Otherwise: bits [subtime .. N-1] high; rem = width - (N - subtime), held in a WIDTH_W+1-bit register; go to HIGH.
- HIGH, each cycle:
  - rem > N: load all ones; rem -= N.
  - rem <= N: load bits [0 .. rem-1] high, others low; go to IDLE.
- The rising edge therefore falls at sample index subtime of cycle event_time. The falling edge falls after exactly width high samples.
- Loading the final vector and returning to IDLE happen on the same edge. Any lead of 2 or more then guarantees at least one all-zero vector (the ARMED cycle) before the next pulse, so back-to-back edges are always visible.
- Inputs other than event_valid are don't-care when no handshake occurs. event_valid with ready low is held off, not dropped.

## Timing
- samples has one-cycle registered latency. The decision is made in cycle event_time-1, and the vector is valid during cycle event_time.
- Minimum lead time is 2 cycles, measured from the acceptance cycle (now at acceptance) to event_time.
- Window for accepted events: event_time is up to 2^(TIME_W-1)-1 cycles ahead, with wrap-aware comparison.
- late asserts in the cycle after the dropping handshake, for exactly one cycle. event_ready stays high throughout.
- event_ready returns high in the cycle in which the last pulse vector is presented.
- Reset, asynchronous at any time including ARMED or HIGH:
  - samples = 0, now = 0, late = 0.
  - State becomes IDLE, so event_ready = 1 and the latched event is discarded.
  - After release, the first cycle shows now = 0.

## Test plan
- BITS=2, reset release. At now=5 offer time=10, subtime=1, width=2 → ready falls at now=6; samples=4'b0110 at now=10, 0 at now=11; ready high at now=10.
- Offer time=20, subtime=3, width=6 → samples 4'b1000 @20, 4'b1111 @21, 4'b0001 @22, 0 @23.
- Late cases: at now=30 offer time=31 → late=1 at now=31 only, samples stay 0, ready never drops. At now=40 offer time=39 → same result.
- Wrap, TIME_W=8: at now=254 offer time=2, subtime=0, width=4 → samples=4'b1111 at now=2 after wrap, 0 at now=3.
- width=0 at time=50 → accepted, samples 0 throughout, ready high again at now=50. A second event at subtime=0 right after a pulse ending all-high → an all-zero vector separates the two pulses.
- Reset asserted during HIGH of a width=200 pulse → samples=0 and now=0 immediately. After release, event_ready=1 and no residual high samples.
